// File: rtl/ram8_arbiter_pkg.sv
// Shared types and widths for the RAM8 arbiter slice.
// Holds the FSM state codes and the default data/address widths.
package ram8_arbiter_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/ram8_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the RAM8 store.
// Ports: req/we/addr/wdata/ack/rdata per requester, busy, ram_r/w/addr/d/o.
interface ram8_arbiter_if;
    import ram8_arbiter_pkg::*;

    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;

    logic              busy;
    logic              ram_r;
    logic              ram_w;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_d;
    logic [DATA_W-1:0] ram_o;

    // Arbiter side.
    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  ram_o,
        output ack0, rdata0, ack1, rdata1,
        output busy, ram_r, ram_w, ram_addr, ram_d
    );

    // Requesters plus RAM side.
    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output ram_o,
        input  ack0, rdata0, ack1, rdata1,
        input  busy, ram_r, ram_w, ram_addr, ram_d
    );

endinterface

// File: rtl/ram8_arbiter_rr_arb2.sv
// Two-way round-robin grant logic, purely combinational.
// Ports: req0_i, req1_i, ptr_i (priority port) -> gnt0_o, gnt1_o (one-hot or zero).
module rr_arb2
    import ram8_arbiter_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic ptr_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    // On contention the pointer port wins; a lone request always wins.
    assign gnt0_o = req0_i & (~req1_i | ~ptr_i);
    assign gnt1_o = req1_i & (~req0_i |  ptr_i);

endmodule

// File: rtl/ram8_arbiter.sv
// Round-robin arbiter/sequencer in front of the RAM8 8x16 store.
// Ports: clk, rst_n (sync, active-low), bus (slave modport of ram8_arbiter_if).
module ram8_arbiter
    import ram8_arbiter_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    ram8_arbiter_if.slave  bus
);

    state_t state_q, state_d;

    logic              ptr_q;
    logic              gnt_id_q;
    logic              cmd_we_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [DATA_W-1:0] cmd_wdata_q;

    logic              ack0_q, ack1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic              busy_q;
    logic              ram_r_q, ram_w_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_d_q;

    logic areq0, areq1;
    logic gnt0, gnt1;
    logic grant;

    // The port being acked in DONE may still hold req; mask it out.
    always_comb begin
        areq0 = bus.req0;
        areq1 = bus.req1;
        if (state_q == DONE) begin
            if (gnt_id_q) areq1 = 1'b0;
            else          areq0 = 1'b0;
        end
    end

    rr_arb2 u_arb (
        .req0_i (areq0),
        .req1_i (areq1),
        .ptr_i  (ptr_q),
        .gnt0_o (gnt0),
        .gnt1_o (gnt1)
    );

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (gnt0 || gnt1) begin
                    state_d = SETUP;
                    grant   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = HOLD;
            HOLD:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the current state, so the bus
    // pins trail the state register by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            gnt_id_q    <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            busy_q      <= 1'b0;
            ram_r_q     <= 1'b0;
            ram_w_q     <= 1'b0;
            ram_addr_q  <= '0;
            ram_d_q     <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                gnt_id_q    <= gnt1;
                ptr_q       <= gnt0;
                cmd_we_q    <= gnt1 ? bus.we1    : bus.we0;
                cmd_addr_q  <= gnt1 ? bus.addr1  : bus.addr0;
                cmd_wdata_q <= gnt1 ? bus.wdata1 : bus.wdata0;
            end
            busy_q  <= (state_q == SETUP) || (state_q == ACCESS)
                    || (state_q == HOLD);
            ram_w_q <= (state_q == ACCESS) && cmd_we_q;
            ram_r_q <= ((state_q == ACCESS) || (state_q == HOLD))
                    && !cmd_we_q;
            if (state_q == SETUP) begin
                ram_addr_q <= cmd_addr_q;
                ram_d_q    <= cmd_wdata_q;
            end
            ack0_q <= (state_q == DONE) && !gnt_id_q;
            ack1_q <= (state_q == DONE) &&  gnt_id_q;
            if ((state_q == HOLD) && !cmd_we_q) begin
                if (gnt_id_q) rdata1_q <= bus.ram_o;
                else          rdata0_q <= bus.ram_o;
            end
        end
    end

    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.rdata0   = rdata0_q;
    assign bus.rdata1   = rdata1_q;
    assign bus.busy     = busy_q;
    assign bus.ram_r    = ram_r_q;
    assign bus.ram_w    = ram_w_q;
    assign bus.ram_addr = ram_addr_q;
    assign bus.ram_d    = ram_d_q;

endmodule
